// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter.
package dpram_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 8;
  localparam int IDX_W    = 3;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             psel;
  } rd_ent_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-find-first: first index at or after start (with wrap) whose
// request and mask bits are both set.
module rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] cand;

  assign cand = req & mask;

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j     = 0;
    jj    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && cand[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dual-port RAM among NREQ requesters: zeroing sweep after reset,
// then up to two round-robin grants per cycle with same-address hazard skip.
//
// state  | meaning
// S_INIT | sweep writes zero to two addresses per cycle, no grants
// S_RUN  | arbitration active, left only by reset
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic              init_done,
  output logic [AW-1:0]     ram_addr1,
  output logic [AW-1:0]     ram_addr2,
  output logic [DW-1:0]     ram_datain1,
  output logic [DW-1:0]     ram_datain2,
  output logic              ram_we1,
  output logic              ram_we2,
  input  logic [DW-1:0]     ram_dout1,
  input  logic [DW-1:0]     ram_dout2
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [AW-2:0]   init_cnt;
  logic [IW-1:0]   rr_ptr, p1_idx, p2_idx, p2_start;
  logic            p1_found, p2_found, g1, g2;
  logic [NREQ-1:0] hazard, p2_mask;
  logic [AW-1:0]   p1_addr, p2_addr;
  logic [DW-1:0]   p1_wdata, p2_wdata;
  logic            p1_we, p2_we;
  rd_ent_t [1:0]   rd_pipe;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick1 (
    .req   (req),
    .start (rr_ptr),
    .mask  ({NREQ{1'b1}}),
    .found (p1_found),
    .idx   (p1_idx)
  );

  assign p1_addr  = req_addr[p1_idx*AW +: AW];
  assign p1_wdata = req_wdata[p1_idx*DW +: DW];
  assign p1_we    = req_we[p1_idx];

  // A candidate touching P1's address is skipped unless both sides only read.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NREQ; i++)
      hazard[i] = (req_addr[i*AW +: AW] == p1_addr) && (req_we[i] || p1_we);
  end

  assign p2_start = IW'(wrap_inc(int'(p1_idx), NREQ));
  assign p2_mask  = ~hazard & ~(NREQ'(1) << p1_idx);

  rr_pick #(.N(NREQ), .IW(IW)) u_pick2 (
    .req   (req),
    .start (p2_start),
    .mask  (p2_mask),
    .found (p2_found),
    .idx   (p2_idx)
  );

  assign p2_addr  = req_addr[p2_idx*AW +: AW];
  assign p2_wdata = req_wdata[p2_idx*DW +: DW];
  assign p2_we    = req_we[p2_idx];

  assign g1 = rst_n && (state == S_RUN) && p1_found;
  assign g2 = g1 && p2_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == S_RUN);
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt         = '0;
    ram_addr1   = '0;
    ram_addr2   = '0;
    ram_datain1 = '0;
    ram_datain2 = '0;
    ram_we1     = 1'b0;
    ram_we2     = 1'b0;
    if (rst_n) begin
      case (state)
        S_INIT: begin
          ram_addr1 = {init_cnt, 1'b0};
          ram_addr2 = {init_cnt, 1'b1};
          ram_we1   = 1'b1;
          ram_we2   = 1'b1;
          if (&init_cnt) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (g1) begin
            gnt[p1_idx] = 1'b1;
            ram_addr1   = p1_addr;
            ram_datain1 = p1_wdata;
            ram_we1     = p1_we;
          end
          if (g2) begin
            gnt[p2_idx] = 1'b1;
            ram_addr2   = p2_addr;
            ram_datain2 = p2_wdata;
            ram_we2     = p2_we;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (g2) begin
      rr_ptr <= IW'(wrap_inc(int'(p2_idx), NREQ));
    end else if (g1) begin
      rr_ptr <= IW'(wrap_inc(int'(p1_idx), NREQ));
    end
  end

  // Slot 0 follows RAM port 1, slot 1 port 2; the RAM answers one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      rd_pipe[0] <= '{valid: g1 && !p1_we, idx: IDX_W'(p1_idx), psel: 1'b0};
      rd_pipe[1] <= '{valid: g2 && !p2_we, idx: IDX_W'(p2_idx), psel: 1'b1};
      for (int i = 0; i < NREQ; i++) begin
        rvalid[i] <= 1'b0;
        for (int s = 0; s < 2; s++) begin
          if (rd_pipe[s].valid && rd_pipe[s].idx == IDX_W'(i)) begin
            rvalid[i]          <= 1'b1;
            rdata[i*DW +: DW]  <= rd_pipe[s].psel ? ram_dout2 : ram_dout1;
          end
        end
      end
    end
  end

endmodule
